// File: rtl/spi_pkg.sv
// Shared SPI definitions used by the slave (and the existing master):
// default frame width, FSM state encodings, mode constants and a
// counter-width helper.
package spi_pkg;

  localparam int unsigned SPI_DATA_W = 8;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_SHIFT = 1'b1;

  // Mode 0: clock idles low, data sampled on the rising edge.
  localparam logic CPOL = 1'b0;
  localparam logic CPHA = 1'b0;

  typedef enum logic {
    IDLE  = ST_IDLE,
    SHIFT = ST_SHIFT
  } spi_state_e;

  // Width of a counter that must hold 0 .. n-1.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer with registered single-cycle rise/fall strobes.
// Ports:
//   clk, reset (async, active-low)
//   d     asynchronous input
//   q     synchronized level (last stage)
//   rise  one-clk strobe on a 0->1 transition of q
//   fall  one-clk strobe on a 1->0 transition of q
// STAGES must be at least 2; RST_VAL is the idle level the chain holds in reset.
module spi_sync #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sh;
  logic              q_d;

  assign q = sh[STAGES-1];

  // Synchronizer chain, delayed copy of the last stage, and edge strobes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sh   <= {STAGES{RST_VAL}};
      q_d  <= RST_VAL;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      sh   <= {sh[STAGES-2:0], d};
      q_d  <= sh[STAGES-1];
      rise <= sh[STAGES-1] & ~q_d;
      fall <= ~sh[STAGES-1] & q_d;
    end
  end

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 responder, MSB first, one DATA_W-bit byte per frame, ss active-low.
// All SPI inputs are oversampled in the clk domain.
// Ports:
//   clk, reset (async, active-low)
//   sclk, ss, mosi  from the SPI master
//   miso            serial data to the master
//   tdata           byte to transmit, loaded at frame start and each byte boundary
//   rdata           last complete received byte
//   rvalid          one-clk pulse when rdata updates
//   busy            high while a frame is active
// Build option SPI_SLAVE_ECHO_EN: each transmit load takes rdata instead of
// tdata, so the master reads back the previously received byte.
module spi_slave
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W      = SPI_DATA_W,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sclk,
  input  logic              ss,
  input  logic              mosi,
  output logic              miso,
  input  logic [DATA_W-1:0] tdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              busy
);

  localparam int unsigned CNT_W = cnt_w(DATA_W);

  logic sclk_q_unused, sclk_rise, sclk_fall;
  logic ss_q, ss_rise, ss_fall;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  spi_state_e        state;
  logic [CNT_W-1:0]  bitcnt;
  logic [DATA_W-2:0] rx_sh;
  logic [DATA_W-1:0] tx_sh;
  logic              reload;
  logic              armed;
  logic [SYNC_STAGES:0] flush;

  logic [DATA_W-1:0] rx_next_c;
  logic [DATA_W-1:0] load_c;

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
    .clk  (clk),
    .reset(reset),
    .d    (sclk),
    .q    (sclk_q_unused),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss_sync (
    .clk  (clk),
    .reset(reset),
    .d    (ss),
    .q    (ss_q),
    .rise (ss_rise),
    .fall (ss_fall)
  );

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi_sync (
    .clk  (clk),
    .reset(reset),
    .d    (mosi),
    .q    (mosi_s),
    .rise (mosi_rise_unused),
    .fall (mosi_fall_unused)
  );

  // Received byte including the bit arriving on the current rise.
  assign rx_next_c = {rx_sh, mosi_s};

  // Value loaded into the transmit shifter at frame start / byte boundary.
`ifdef SPI_SLAVE_ECHO_EN
  logic unused_tdata;
  assign unused_tdata = ^tdata;
  assign load_c = rdata;
`else
  assign load_c = tdata;
`endif

  assign miso = (state == SHIFT) ? tx_sh[DATA_W-1] : 1'b0;
  assign busy = (state == SHIFT);

  // Frame FSM. 'armed' blocks the spurious ss_fall seen when reset releases
  // with ss already low: a frame only starts after ss has been seen high
  // through a fully refilled synchronizer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      bitcnt <= '0;
      rx_sh  <= '0;
      tx_sh  <= '0;
      rdata  <= '0;
      rvalid <= 1'b0;
      reload <= 1'b0;
      armed  <= 1'b0;
      flush  <= '0;
    end else begin
      rvalid <= 1'b0;
      flush  <= {flush[SYNC_STAGES-1:0], 1'b1};
      if (flush[SYNC_STAGES] && ss_q) begin
        armed <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (ss_fall && armed) begin
            tx_sh  <= load_c;
            bitcnt <= '0;
            reload <= 1'b0;
            state  <= SHIFT;
          end
        end

        SHIFT: begin
          // ss_rise has priority: a coincident sclk rise is dropped.
          if (ss_rise) begin
            state  <= IDLE;
            bitcnt <= '0;
            reload <= 1'b0;
          end else begin
            if (sclk_rise) begin
              rx_sh <= rx_next_c[DATA_W-2:0];
              if (bitcnt == CNT_W'(DATA_W - 1)) begin
                bitcnt <= '0;
                reload <= 1'b1;
                rdata  <= rx_next_c;
                rvalid <= 1'b1;
              end else begin
                bitcnt <= bitcnt + CNT_W'(1);
              end
            end
            // Rise and fall strobes are never coincident.
            if (sclk_fall) begin
              if (reload) begin
                tx_sh  <= load_c;
                reload <= 1'b0;
              end else begin
                tx_sh <= {tx_sh[DATA_W-2:0], 1'b0};
              end
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: a mode-0 master model drives frames,
// received bytes are queued as expectations and checked when rvalid pulses.
// Expectations adapt to the SPI_SLAVE_ECHO_EN build option.
module tb_spi_slave;

  localparam int HALF = 80;  // sclk half period in time units (clk period 10)

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       sclk = 1'b0;
  logic       ss = 1'b1;
  logic       mosi = 1'b0;
  logic       miso;
  logic [7:0] tdata = 8'h00;
  logic [7:0] rdata;
  logic       rvalid;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int rvalid_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] model_rdata = 8'h00;
  logic [7:0] sb_exp;

  spi_slave #(.DATA_W(8), .SYNC_STAGES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .sclk  (sclk),
    .ss    (ss),
    .mosi  (mosi),
    .miso  (miso),
    .tdata (tdata),
    .rdata (rdata),
    .rvalid(rvalid),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  // Scoreboard: every rvalid pulse must match the oldest queued byte.
  always @(negedge clk) begin
    if (rvalid === 1'b1) begin
      rvalid_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rvalid: rdata=%h, no byte expected", rdata);
      end else begin
        sb_exp = exp_q.pop_front();
        if (rdata !== sb_exp) begin
          errors++;
          $display("FAIL rdata_on_rvalid: got %h, expected %h", rdata, sb_exp);
        end
      end
    end
  end

  // Byte the slave should shift out for the next load.
  function automatic logic [7:0] load_exp();
`ifdef SPI_SLAVE_ECHO_EN
    return model_rdata;
`else
    return tdata;
`endif
  endfunction

  // Master model: shifts nbits MSB-first, returns bits captured from miso.
  task automatic spi_bits(input logic [7:0] din, input int nbits,
                          input bit expect_byte, output logic [7:0] dout);
    dout = 8'h00;
    if (expect_byte) exp_q.push_back(din);
    for (int i = 7; i >= 8 - nbits; i--) begin
      mosi = din[i];
      #(HALF);
      dout[i] = miso;
      sclk = 1'b1;
      #(HALF);
      sclk = 1'b0;
    end
    if (expect_byte) model_rdata = din;
  endtask

  task automatic wait_drain(output bit timed_out);
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    timed_out = (exp_q.size() != 0);
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %h, expected 00", rdata); end
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b, expected 0", rvalid); end
    checks++; if (miso !== 1'b0) begin errors++; $display("FAIL reset_miso: got %b, expected 0", miso); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, expected 0", busy); end
  endtask

  task automatic test_idle_noise();
    int cnt0;
    logic [7:0] seen;
    cnt0 = rvalid_cnt;
    ss = 1'b1;
    tdata = 8'hA5;
    seen = 8'h00;
    for (int i = 0; i < 8; i++) begin
      mosi = 1'b1;
      #(HALF);
      seen = seen | {7'd0, miso};
      sclk = 1'b1;
      #(HALF);
      seen = seen | {7'd0, miso};
      sclk = 1'b0;
    end
    repeat (10) @(negedge clk);
    checks++; if (rvalid_cnt != cnt0) begin errors++; $display("FAIL idle_rvalid: got %0d pulses, expected 0", rvalid_cnt - cnt0); end
    checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL idle_rdata: got %h, expected 00", rdata); end
    checks++; if (seen !== 8'h00) begin errors++; $display("FAIL idle_miso: got %h, expected 00", seen); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b, expected 0", busy); end
  endtask

  task automatic test_single();
    int cnt0;
    bit to;
    logic [7:0] got, exp_tx;
    cnt0 = rvalid_cnt;
    tdata = 8'hA3;
    exp_tx = load_exp();
    ss = 1'b0;
    spi_bits(8'h05, 8, 1'b1, got);
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_active: got %b, expected 1", busy); end
    #(HALF);
    ss = 1'b1;
    wait_drain(to);
    repeat (10) @(negedge clk);
    checks++; if (to) begin errors++; $display("FAIL single_rvalid_timeout: %0d bytes pending, expected 0", exp_q.size()); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_idle: got %b, expected 0", busy); end
    checks++; if (got !== exp_tx) begin errors++; $display("FAIL single_miso: got %h, expected %h", got, exp_tx); end
    checks++; if (rvalid_cnt - cnt0 != 1) begin errors++; $display("FAIL single_pulses: got %0d, expected 1", rvalid_cnt - cnt0); end
    checks++; if (rdata !== 8'h05) begin errors++; $display("FAIL single_rdata: got %h, expected 05", rdata); end
  endtask

  task automatic test_back_to_back();
    int cnt0;
    bit to;
    logic [7:0] got1, got2, exp1, exp2;
    cnt0 = rvalid_cnt;
    tdata = 8'hA3;
    exp1 = load_exp();
    ss = 1'b0;
    repeat (8) @(negedge clk);
    tdata = 8'h3C;
    spi_bits(8'h05, 8, 1'b1, got1);
    exp2 = load_exp();
    spi_bits(8'hC8, 8, 1'b1, got2);
    #(HALF);
    ss = 1'b1;
    wait_drain(to);
    repeat (10) @(negedge clk);
    checks++; if (to) begin errors++; $display("FAIL b2b_rvalid_timeout: %0d bytes pending, expected 0", exp_q.size()); end
    checks++; if (got1 !== exp1) begin errors++; $display("FAIL b2b_miso_byte1: got %h, expected %h", got1, exp1); end
    checks++; if (got2 !== exp2) begin errors++; $display("FAIL b2b_miso_byte2: got %h, expected %h", got2, exp2); end
    checks++; if (rvalid_cnt - cnt0 != 2) begin errors++; $display("FAIL b2b_pulses: got %0d, expected 2", rvalid_cnt - cnt0); end
    checks++; if (rdata !== 8'hC8) begin errors++; $display("FAIL b2b_rdata: got %h, expected c8", rdata); end
  endtask

  task automatic test_ss_race();
    int cnt0;
    logic [7:0] got;
    cnt0 = rvalid_cnt;
    tdata = 8'h11;
    ss = 1'b0;
    spi_bits(8'h77, 7, 1'b0, got);
    mosi = 1'b1;
    #(HALF);
    sclk = 1'b1;
    ss = 1'b1;
    #(HALF);
    sclk = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (rvalid_cnt != cnt0) begin errors++; $display("FAIL race_rvalid: got %0d pulses, expected 0", rvalid_cnt - cnt0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL race_busy: got %b, expected 0", busy); end
    checks++; if (rdata !== model_rdata) begin errors++; $display("FAIL race_rdata: got %h, expected %h", rdata, model_rdata); end
  endtask

  task automatic test_abort();
    int cnt0;
    bit to;
    logic [7:0] got, exp_tx;
    cnt0 = rvalid_cnt;
    tdata = 8'h96;
    ss = 1'b0;
    spi_bits(8'hFF, 4, 1'b0, got);
    #(HALF);
    ss = 1'b1;
    repeat (10) @(negedge clk);
    checks++; if (rvalid_cnt != cnt0) begin errors++; $display("FAIL abort_rvalid: got %0d pulses, expected 0", rvalid_cnt - cnt0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b, expected 0", busy); end
    checks++; if (rdata !== model_rdata) begin errors++; $display("FAIL abort_rdata: got %h, expected %h", rdata, model_rdata); end
    exp_tx = load_exp();
    ss = 1'b0;
    spi_bits(8'h81, 8, 1'b1, got);
    #(HALF);
    ss = 1'b1;
    wait_drain(to);
    repeat (10) @(negedge clk);
    checks++; if (to) begin errors++; $display("FAIL abort_next_timeout: %0d bytes pending, expected 0", exp_q.size()); end
    checks++; if (rdata !== 8'h81) begin errors++; $display("FAIL abort_next_rdata: got %h, expected 81", rdata); end
    checks++; if (got !== exp_tx) begin errors++; $display("FAIL abort_next_miso: got %h, expected %h", got, exp_tx); end
  endtask

  task automatic test_reset_mid_frame();
    int cnt0;
    bit to;
    logic [7:0] got, exp_tx;
    tdata = 8'hFF;
    ss = 1'b0;
    spi_bits(8'hA5, 3, 1'b0, got);
    #(HALF / 2);
    reset = 1'b0;
    #1;
    model_rdata = 8'h00;
    checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL rstmid_rdata: got %h, expected 00", rdata); end
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL rstmid_rvalid: got %b, expected 0", rvalid); end
    checks++; if (miso !== 1'b0) begin errors++; $display("FAIL rstmid_miso: got %b, expected 0", miso); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b, expected 0", busy); end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    cnt0 = rvalid_cnt;
    spi_bits(8'hFF, 8, 1'b0, got);
    repeat (10) @(negedge clk);
    checks++; if (rvalid_cnt != cnt0) begin errors++; $display("FAIL rstmid_stale_ss_rvalid: got %0d pulses, expected 0", rvalid_cnt - cnt0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_stale_ss_busy: got %b, expected 0", busy); end
    ss = 1'b1;
    repeat (10) @(negedge clk);
    tdata = 8'h5A;
    exp_tx = load_exp();
    ss = 1'b0;
    spi_bits(8'h3C, 8, 1'b1, got);
    #(HALF);
    ss = 1'b1;
    wait_drain(to);
    repeat (10) @(negedge clk);
    checks++; if (to) begin errors++; $display("FAIL rstmid_fresh_timeout: %0d bytes pending, expected 0", exp_q.size()); end
    checks++; if (rdata !== 8'h3C) begin errors++; $display("FAIL rstmid_fresh_rdata: got %h, expected 3c", rdata); end
    checks++; if (got !== exp_tx) begin errors++; $display("FAIL rstmid_fresh_miso: got %h, expected %h", got, exp_tx); end
  endtask

`ifdef SPI_SLAVE_ECHO_EN
  task automatic test_echo();
    bit to;
    logic [7:0] got1, got2;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    model_rdata = 8'h00;
    repeat (10) @(negedge clk);
    tdata = 8'hEE;
    ss = 1'b0;
    spi_bits(8'h05, 8, 1'b1, got1);
    #(HALF);
    ss = 1'b1;
    repeat (10) @(negedge clk);
    ss = 1'b0;
    spi_bits(8'h5A, 8, 1'b1, got2);
    #(HALF);
    ss = 1'b1;
    wait_drain(to);
    repeat (10) @(negedge clk);
    checks++; if (to) begin errors++; $display("FAIL echo_timeout: %0d bytes pending, expected 0", exp_q.size()); end
    checks++; if (got1 !== 8'h00) begin errors++; $display("FAIL echo_first: got %h, expected 00", got1); end
    checks++; if (got2 !== 8'h05) begin errors++; $display("FAIL echo_second: got %h, expected 05", got2); end
  endtask
`endif

  initial begin
    repeat (5) @(negedge clk);
    test_reset();
    reset = 1'b1;
    repeat (10) @(negedge clk);
    test_idle_noise();
    test_single();
    test_back_to_back();
    test_ss_race();
    test_abort();
    test_reset_mid_frame();
`ifdef SPI_SLAVE_ECHO_EN
    test_echo();
`endif
    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation still running, expected completion");
    $fatal(1, "timeout");
  end

endmodule
